binary_to_bcd_conv: RTL and testbench
=====================================

// Module: binary_to_bcd_conv
// PURPOSE
//  Sequential 16-bit binary to 4-digit packed BCD converter using shift-add-3 (double dabble).
//  It converts one value per request under a start/done handshake.
//  It feeds display/readout logic that needs decimal digits (thousands..units) and an overflow flag.
//  A single clock domain is used throughout.
// PARAMETERS
//  none. Input width (16) and digit count (4) are fixed.
// PORTS
//  clk     in   1   system clock, rising-edge active
//  rst_n   in   1   reset; asynchronous, active-low
//  start   in   1   conversion request; sampled on rising clk
//  bin     in   16  unsigned binary operand; captured when start is accepted
//  busy    out  1   high while a conversion is in progress
//  done    out  1   one-cycle pulse when results update
//  bcd3    out  4   thousands digit (0-9)
//  bcd2    out  4   hundreds digit (0-9)
//  bcd1    out  4   tens digit (0-9)
//  bcd0    out  4   units digit (0-9)
//  ovf     out  1   high when captured bin > 9999
// BEHAVIOUR
//  - Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
//  - Reset (rst_n=0, async): FSM goes to IDLE.
//    busy=0, done=0, ovf=0, bcd3..bcd0=0, internal shift/count registers cleared.
//  - FSM states:
//    IDLE -> SHIFT when start=1.
//    SHIFT -> DONE after 16 shift iterations.
//    DONE -> IDLE unconditionally.
//  - IDLE, start=1 at edge N:
//    bin latched into the shift register; 20-bit BCD scratch cleared; counter=0; busy=1 from N.
//  - SHIFT, each cycle:
//    every 4-bit scratch nibble >=5 gets +3; then {scratch,shift} shifts left 1; counter++.
//    Exactly 16 SHIFT cycles.
//  - DONE (1 cycle):
//    bcd3..bcd0 <= scratch[15:0]; ovf <= (scratch[19:16]!=0); done=1; busy=0.
//    Return to IDLE next edge.
//  - Latency: done asserts 17 cycles after the accepting edge; a new start is accepted in the cycle after done.
//  - start while busy (SHIFT or DONE) is ignored; no queueing. bin changes during busy have no effect.
//  - Outputs bcd*/ovf hold their last result until the next DONE. They do not change during SHIFT.
//  - Overflow (bin 10000..65535):
//    digits show the value mod 10000, i.e. the lower four decimal digits; ovf=1.
//  - Every output digit is always 0-9 (never 4'hA-F).
//  - Reset mid-conversion aborts immediately: outputs zero, no done pulse.
//  - start held high continuously: a conversion restarts each time IDLE is re-entered, using current bin.
// TESTING
//  - Reset then start with bin=0 -> after 17 cycles done=1; bcd3..0=0,0,0,0; ovf=0.
//  - Sweep bin=0..49 (each: start, wait done) -> digits match decimal value, e.g. 49 -> 0,0,4,9; ovf=0.
//  - bin=9999 -> 9,9,9,9 ovf=0. bin=1234 -> 1,2,3,4.
//    bin=10000 -> 0,0,0,0 ovf=1. bin=65535 -> 5,5,3,5 ovf=1.
//  - Start bin=100; pulse start again with bin=7 at cycle 5 -> ignored.
//    done once at cycle 17 with 0,1,0,0; busy stays 1 until done.
//  - Assert rst_n=0 at cycle 8 of a conversion of 4321 -> outputs 0, no done.
//    After release, a new start with 4321 -> 4,3,2,1.
//  - Random bin x1000 vs reference model (x/1000%10 .. x%10, ovf=x>9999).
//    Check busy/done timing and that all digits are <=9.

Source files
------------

// File: rtl/binary_to_bcd_conv.sv
// binary_to_bcd_conv: sequential 16-bit binary to 4-digit packed BCD (double dabble) with start/done handshake
module binary_to_bcd_conv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [3:0]  bcd3,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd0,
  output logic        ovf
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [19:0] scratch_q, scratch_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [19:0] adj;
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 5; i++)
      adj[4*i+:4] = (scratch_q[4*i+:4] >= 4'd5) ? scratch_q[4*i+:4] + 4'd3 : scratch_q[4*i+:4];
  end
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        shift_d   = bin;
        scratch_d = '0;
        cnt_d     = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        {scratch_d, shift_d} = {adj[18:0], shift_q, 1'b0};
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'd15) ? DONE : SHIFT;
      end
      DONE: begin
        bcd_d   = scratch_q[15:0];
        ovf_d   = |scratch_q[19:16];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign {bcd3, bcd2, bcd1, bcd0} = bcd_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_binary_to_bcd_conv.sv
// tb_binary_to_bcd_conv: directed and reference-model checks of the double-dabble converter
module tb_binary_to_bcd_conv;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin = '0;
  logic        busy, done, ovf;
  logic [3:0]  bcd3, bcd2, bcd1, bcd0;
  int total = 0;
  int bad = 0;

  binary_to_bcd_conv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin), .busy(busy), .done(done),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] ref_out(input int v);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'((v / 1000) % 10);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d3, d2, d1, d0, v > 9999};
  endfunction

  task automatic run(input logic [15:0] v, output int lat, output bit busy_bad);
    @(negedge clk);
    bin = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    busy_bad = 1'b0;
    while (!done && lat < 40) begin
      if (!busy) busy_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, ovf, bcd3, bcd2, bcd1, bcd0} !== 19'd0) begin
      bad++;
      $display("FAIL reset: outputs=%h want 0", {busy, done, ovf, bcd3, bcd2, bcd1, bcd0});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero;
    int lat;
    bit bb;
    run(16'd0, lat, bb);
    total++;
    if (lat !== 17) begin bad++; $display("FAIL zero_latency: got %0d want 17", lat); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_at_done: got %b want 0", busy); end
    total++;
    if (bb) begin bad++; $display("FAIL zero_busy_during: busy dropped early, want 1"); end
    total++;
    if ({bcd3, bcd2, bcd1, bcd0, ovf} !== 17'd0) begin
      bad++;
      $display("FAIL zero_digits: got %h ovf=%b want 0000 ovf=0", {bcd3, bcd2, bcd1, bcd0}, ovf);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_sweep;
    int lat;
    bit bb;
    for (int v = 0; v < 50; v++) begin
      run(16'(v), lat, bb);
      total++;
      if ({bcd3, bcd2, bcd1, bcd0, ovf} !== ref_out(v) || lat != 17) begin
        bad++;
        $display("FAIL sweep_%0d: got %h ovf=%b lat=%0d want %h lat=17", v, {bcd3, bcd2, bcd1, bcd0}, ovf, lat, ref_out(v) >> 1);
      end
    end
  endtask

  task automatic test_directed;
    logic [15:0] vin [4] = '{16'd9999, 16'd1234, 16'd10000, 16'd65535};
    logic [16:0] want [4] = '{{16'h9999, 1'b0}, {16'h1234, 1'b0}, {16'h0000, 1'b1}, {16'h5535, 1'b1}};
    int lat;
    bit bb;
    for (int i = 0; i < 4; i++) begin
      run(vin[i], lat, bb);
      total++;
      if ({bcd3, bcd2, bcd1, bcd0, ovf} !== want[i]) begin
        bad++;
        $display("FAIL directed_%0d: got %h ovf=%b want %h ovf=%b", vin[i], {bcd3, bcd2, bcd1, bcd0}, ovf, want[i][16:1], want[i][0]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int first = 0;
    int dones = 0;
    bit bb = 1'b0;
    @(negedge clk);
    bin = 16'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) begin bin = 16'd7; start = 1'b1; end
      if (k == 6) start = 1'b0;
      if (k < 17 && !busy) bb = 1'b1;
      if (done) begin dones++; if (first == 0) first = k; end
    end
    total++;
    if (first !== 17) begin bad++; $display("FAIL ignore_latency: got %0d want 17", first); end
    total++;
    if (dones !== 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
    total++;
    if (bb) begin bad++; $display("FAIL ignore_busy: busy dropped before done, want 1"); end
    total++;
    if ({bcd3, bcd2, bcd1, bcd0, ovf} !== {16'h0100, 1'b0}) begin
      bad++;
      $display("FAIL ignore_digits: got %h ovf=%b want 0100 ovf=0", {bcd3, bcd2, bcd1, bcd0}, ovf);
    end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    int lat;
    bit bb;
    @(negedge clk);
    bin = 16'd4321;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, ovf, bcd3, bcd2, bcd1, bcd0} !== 19'd0) begin
      bad++;
      $display("FAIL reset_mid: outputs=%h want 0", {busy, done, ovf, bcd3, bcd2, bcd1, bcd0});
    end
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 3) rst_n = 1'b1;
      if (done) dones++;
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL reset_mid_done: got %0d pulses want 0", dones); end
    run(16'd4321, lat, bb);
    total++;
    if ({bcd3, bcd2, bcd1, bcd0, ovf} !== {16'h4321, 1'b0} || lat != 17) begin
      bad++;
      $display("FAIL reset_mid_rerun: got %h ovf=%b lat=%0d want 4321 ovf=0 lat=17", {bcd3, bcd2, bcd1, bcd0}, ovf, lat);
    end
  endtask

  task automatic test_back_to_back;
    int first = 0;
    int second = 0;
    logic [15:0] d1 = '1;
    logic [15:0] d2 = '1;
    @(negedge clk);
    bin = 16'd42;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done && first == 0) begin first = k; d1 = {bcd3, bcd2, bcd1, bcd0}; bin = 16'd77; end
      else if (done && second == 0) begin second = k; d2 = {bcd3, bcd2, bcd1, bcd0}; end
    end
    start = 1'b0;
    for (int k = 0; k < 40 && busy; k++) @(posedge clk);
    #1;
    total++;
    if (first !== 17 || d1 !== 16'h0042) begin
      bad++;
      $display("FAIL b2b_first: at %0d digits %h want 17 and 0042", first, d1);
    end
    total++;
    if (second !== 35 || d2 !== 16'h0077) begin
      bad++;
      $display("FAIL b2b_second: at %0d digits %h want 35 and 0077", second, d2);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_drain: busy=%b want 0", busy); end
  endtask

  task automatic test_random;
    int lat;
    bit bb;
    int v;
    for (int i = 0; i < 1000; i++) begin
      v = int'($urandom_range(0, 65535));
      run(16'(v), lat, bb);
      total++;
      if ({bcd3, bcd2, bcd1, bcd0, ovf} !== ref_out(v) || lat != 17 || bb || busy !== 1'b0) begin
        bad++;
        $display("FAIL random_%0d: got %h ovf=%b lat=%0d busy=%b want %h ovf=%b lat=17", v,
                 {bcd3, bcd2, bcd1, bcd0}, ovf, lat, busy, ref_out(v) >> 1, ref_out(v) & 17'd1);
      end
      total++;
      if (bcd3 > 4'd9 || bcd2 > 4'd9 || bcd1 > 4'd9 || bcd0 > 4'd9) begin
        bad++;
        $display("FAIL random_digit_range: got %h want each digit <= 9", {bcd3, bcd2, bcd1, bcd0});
      end
    end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_sweep;
    test_directed;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
